// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW compressor datapath.
//   LZW_CODE_W     : default width of an LZW output code
//   EOF_CODE       : byte value the core uses as end-of-file marker
//   LZW_FIRST_FREE : first dictionary code after the 256 literal codes
//   packer_state_t : state encoding of the code packer FSM
package lzw_pkg;

    localparam int          LZW_CODE_W     = 12;
    localparam logic [7:0]  EOF_CODE       = 8'h0D;
    localparam int          LZW_FIRST_FREE = 256;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } packer_state_t;

endpackage

// File: rtl/lzw_code_packer.sv
// Packs fixed-width LZW codes MSB-first into a byte stream.
// Two 12-bit codes become three bytes. When the core signals lzw_done, any
// residual bits leave as one zero-padded byte, then final_done goes high and
// stays high until reset.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   code_in/valid/ready: code input handshake
//   lzw_done           : core has issued its last code (level or pulse)
//   byte_out/valid/ready: byte output handshake
//   final_done         : sticky, every byte including the tail has left
//   byte_cnt           : bytes handed off since reset, wraps
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready; once byte_valid is up, byte_out
// holds until the transfer. code_ready and byte_valid are decoded from
// registers only, so there is no combinational path from code_valid or
// byte_ready to any output.
//
// CODE_W must lie in 8..16.
module lzw_code_packer
    import lzw_pkg::*;
#(
    parameter int CODE_W = LZW_CODE_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              lzw_done,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              final_done,
    output logic [CNT_W-1:0]  byte_cnt
);

    localparam int ACC_W    = CODE_W + 8;
    localparam int CNT_BITS = $clog2(ACC_W);

    localparam logic [CNT_BITS-1:0] EIGHT    = CNT_BITS'(8);
    localparam logic [CNT_BITS-1:0] CODE_INC = CNT_BITS'(CODE_W);

    packer_state_t        state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 done_pend_q, done_pend_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    // Keeps code_ready low for the first cycle after reset release.
    logic                 ready_en_q, ready_en_d;

    logic                 code_hs;
    logic                 byte_hs;
    logic [ACC_W-1:0]     run_w;
    logic [ACC_W-1:0]     flush_w;

    // Output decode from registered state.
    always_comb begin
        code_ready = 1'b0;
        byte_valid = 1'b0;
        byte_out   = 8'h00;
        // Top 8 valid bits moved down to [7:0].
        run_w      = acc_q >> (cnt_q - EIGHT);
        // Residual bits (fewer than 8) moved up so they sit at [7:8-cnt].
        flush_w    = acc_q << (EIGHT - cnt_q);
        case (state_q)
            RUN: begin
                code_ready = ready_en_q && (cnt_q < EIGHT) && !done_pend_q;
                if (cnt_q >= EIGHT) begin
                    byte_valid = 1'b1;
                    byte_out   = run_w[7:0];
                end
            end
            FLUSH: begin
                if (cnt_q != '0) begin
                    byte_valid = 1'b1;
                    byte_out   = flush_w[7:0];
                end
            end
            default: ;
        endcase
    end

    assign code_hs    = code_ready && code_valid;
    assign byte_hs    = byte_valid && byte_ready;
    assign final_done = (state_q == DONE);
    assign byte_cnt   = byte_cnt_q;

    // Next-state logic. code_ready needs cnt < 8 and byte_valid needs
    // cnt >= 8, so the two handshakes never happen in the same cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        done_pend_d = done_pend_q;
        byte_cnt_d  = byte_cnt_q;
        ready_en_d  = 1'b1;
        case (state_q)
            RUN: begin
                if (lzw_done) begin
                    done_pend_d = 1'b1;
                end
                if (code_hs) begin
                    acc_d = (acc_q << CODE_W) | ACC_W'(code_in);
                    cnt_d = cnt_q + CODE_INC;
                end else if (byte_hs) begin
                    cnt_d = cnt_q - EIGHT;
                end
                if (done_pend_q && (cnt_q < EIGHT) && !code_hs) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else if (byte_hs) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: ;
        endcase
        if (byte_hs) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            acc_q       <= '0;
            cnt_q       <= '0;
            done_pend_q <= 1'b0;
            byte_cnt_q  <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            done_pend_q <= done_pend_d;
            byte_cnt_q  <= byte_cnt_d;
            ready_en_q  <= ready_en_d;
        end
    end

endmodule

// File: tb/tb_lzw_code_packer.sv
// Directed bench for lzw_code_packer: hand-computed byte sequences pushed
// into an expected queue, checked by a negedge monitor that also verifies
// byte_out stability during stalls.
module tb_lzw_code_packer;

    logic        clk;
    logic        rst;
    logic [11:0] code_in;
    logic        code_valid;
    logic        code_ready;
    logic        lzw_done;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        final_done;
    logic [15:0] byte_cnt;

    lzw_code_packer #(.CODE_W(12), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .lzw_done   (lzw_done),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .final_done (final_done),
        .byte_cnt   (byte_cnt)
    );

    // ---------------- clock / reset block ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs_cyc = 0;
    bit rand_mode = 1'b0;

    logic [7:0] exp_q[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- byte_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) byte_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        bit         stall = 1'b0;
        logic [7:0] hold_byte = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", byte_valid, 1);
                    check("hold_byte", byte_out, hold_byte);
                end
                if (byte_valid && byte_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_out", byte_out, e);
                    end
                    last_hs_cyc = cyc;
                end
                stall     = byte_valid && !byte_ready;
                hold_byte = byte_out;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge.
    task automatic check_reset_outs(input string tag);
        check({tag, "_code_ready"}, code_ready, 0);
        check({tag, "_byte_valid"}, byte_valid, 0);
        check({tag, "_byte_out"},   byte_out,   0);
        check({tag, "_final_done"}, final_done, 0);
        check({tag, "_byte_cnt"},   byte_cnt,   0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        code_valid = 1'b0;
        lzw_done   = 1'b0;
        code_in    = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_reset_outs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_first_cycle", code_ready, 0);
        @(negedge clk);
        check("ready_second_cycle", code_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [11:0] c, input bit with_done, output int hs_cyc);
        bit got = 1'b0;
        hs_cyc     = 0;
        code_in    = c;
        code_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = code_ready;
        end
        check("code_accept", got, 1);
        if (got) begin
            lzw_done = with_done;
            hs_cyc   = cyc;
            @(posedge clk);
            #1;
        end
        code_valid = 1'b0;
        lzw_done   = 1'b0;
    endtask

    task automatic send_done(output int d_cyc);
        lzw_done = 1'b1;
        d_cyc    = cyc;
        @(posedge clk);
        #1;
        lzw_done = 1'b0;
    endtask

    task automatic wait_final(output int fin_cyc);
        bit seen = 1'b0;
        fin_cyc = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = final_done;
        end
        check("final_seen", seen, 1);
        fin_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t1, t2, t3, fc, dc;
        byte_ready = 1'b1;
        rst        = 1'b1;
        code_valid = 1'b0;
        lzw_done   = 1'b0;
        code_in    = '0;

        // Two codes -> three bytes, no done.
        do_reset();
        exp_q = '{8'h06, 8'h30, 8'h31};
        send_code(12'h063, 1'b0, t1);
        @(negedge clk);
        check("latency_valid", byte_valid, 1);
        check("latency_byte", byte_out, 8'h06);
        @(posedge clk);
        #1;
        send_code(12'h031, 1'b0, t2);
        idle(6);
        check("t1_byte_cnt", byte_cnt, 3);
        check("t1_final_done", final_done, 0);
        check("t1_drained", exp_q.size(), 0);

        // Three codes + done -> five bytes, padded tail 0x80.
        do_reset();
        exp_q = '{8'h06, 8'h30, 8'h31, 8'h03, 8'h80};
        send_code(12'h063, 1'b0, t1);
        send_code(12'h031, 1'b0, t2);
        send_code(12'h038, 1'b0, t3);
        check("tput_code2", t2 - t1, 2);
        check("tput_code3", t3 - t1, 5);
        send_done(dc);
        wait_final(fc);
        check("t2_final_after_hs", fc - last_hs_cyc, 1);
        check("t2_byte_cnt", byte_cnt, 5);
        check("t2_drained", exp_q.size(), 0);
        idle(3);
        check("t2_final_sticky", final_done, 1);
        check("t2_done_code_ready", code_ready, 0);

        // Same stimulus with random backpressure.
        do_reset();
        rand_mode = 1'b1;
        exp_q = '{8'h06, 8'h30, 8'h31, 8'h03, 8'h80};
        send_code(12'h063, 1'b0, t1);
        send_code(12'h031, 1'b0, t2);
        send_code(12'h038, 1'b0, t3);
        send_done(dc);
        wait_final(fc);
        rand_mode  = 1'b0;
        byte_ready = 1'b1;
        check("t3_byte_cnt", byte_cnt, 5);
        check("t3_drained", exp_q.size(), 0);

        // lzw_done together with the final code handshake.
        do_reset();
        exp_q = '{8'h06, 8'h30};
        send_code(12'h063, 1'b1, t1);
        wait_final(fc);
        check("t4_final_after_hs", fc - last_hs_cyc, 1);
        check("t4_byte_cnt", byte_cnt, 2);
        check("t4_drained", exp_q.size(), 0);

        // lzw_done with no codes at all.
        do_reset();
        exp_q.delete();
        send_done(dc);
        wait_final(fc);
        check("t5_final_latency", fc - dc, 3);
        check("t5_byte_cnt", byte_cnt, 0);

        // Reset mid-operation, then a fresh sequence.
        do_reset();
        exp_q = '{8'h06};
        send_code(12'h063, 1'b0, t1);
        @(posedge clk);
        #1;
        check("t6_first_byte_taken", exp_q.size(), 0);
        check("t6_cnt_before_rst", byte_cnt, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q = '{8'h0A, 8'hBC, 8'hDE};
        send_code(12'h0AB, 1'b0, t1);
        send_code(12'hCDE, 1'b0, t2);
        idle(6);
        check("t6_byte_cnt", byte_cnt, 3);
        check("t6_drained", exp_q.size(), 0);
        check("t6_final_done", final_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
